alu_arbiter: RTL and testbench



---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu16.sv | 34 +++
 rtl/alu_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, error constants and FSM encoding for alu_arbiter
//
// Purpose : common definitions used by alu16 and alu_arbiter.
// Contents: opcode localparams, op_valid() decode helper, divide-by-zero
//           error result, and arbiter FSM state encoding.

package alu_pkg;

   localparam int ALU_DW  = 16;
   localparam int ALU_OPW = 5;

   localparam logic [ALU_OPW-1:0] OP_ADD = 5'b00000;
   localparam logic [ALU_OPW-1:0] OP_SUB = 5'b00001;
   localparam logic [ALU_OPW-1:0] OP_AND = 5'b00010;
   localparam logic [ALU_OPW-1:0] OP_OR  = 5'b00011;
   localparam logic [ALU_OPW-1:0] OP_XOR = 5'b00100;
   localparam logic [ALU_OPW-1:0] OP_MUL = 5'b00101;
   localparam logic [ALU_OPW-1:0] OP_DIV = 5'b00111;
   localparam logic [ALU_OPW-1:0] OP_NOT = 5'b01000;
   localparam logic [ALU_OPW-1:0] OP_MOD = 5'b01001;

   // Result reported alongside err=1 when DIV/MOD see a zero divisor.
   localparam logic [ALU_DW-1:0] ERR_DIV0_RESULT = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   // True for every opcode alu16 implements; anything else is flagged.
   function automatic logic op_valid(input logic [ALU_OPW-1:0] op);
      logic ok;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
         OP_MUL, OP_DIV, OP_NOT, OP_MOD: ok = 1'b1;
         default:                        ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/alu16.sv
// rtl/alu16.sv - 16-bit combinational datapath ALU
//
// Purpose : purely combinational 16-bit ALU; all results truncated to 16 bits.
// Ports   : A, B     - operands
//           ALUCtrl  - opcode (see alu_pkg)
//           Result   - 16-bit result (0 for undefined opcodes and zero divisors)

module alu16
   import alu_pkg::*;
(
   input  logic [ALU_DW-1:0]  A,
   input  logic [ALU_DW-1:0]  B,
   input  logic [ALU_OPW-1:0] ALUCtrl,
   output logic [ALU_DW-1:0]  Result
);

   always_comb begin
      Result = '0;
      case (ALUCtrl)
         OP_ADD: Result = A + B;
         OP_SUB: Result = A - B;
         OP_AND: Result = A & B;
         OP_OR:  Result = A | B;
         OP_XOR: Result = A ^ B;
         OP_MUL: Result = A * B;
         // Zero divisor yields 0 here so no X ever leaves the ALU.
         OP_DIV: Result = (B == '0) ? '0 : A / B;
         OP_NOT: Result = ~A;
         OP_MOD: Result = (B == '0) ? '0 : A % B;
         default: Result = '0;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one alu16 between two requesters
//
// Purpose : two valid/ready request ports contend for a single alu16. Operands
//           are registered on grant, the ALU result is captured one cycle later
//           into the owning port's response register, and held until consumed.
// Ports   : clk, rst_n                    - clock, async active-low reset
//           reqN_valid/ready/a/b/op       - request handshake and operands
//           rspN_valid/ready/result/err   - response handshake and result
//           op_count                      - completed operations (wraps)
//           busy                          - a transaction is in flight

module alu_arbiter
   import alu_pkg::*;
#(
   parameter int DW   = 16,
   parameter int OPW  = 5,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            rst_n,

   input  logic            req0_valid,
   output logic            req0_ready,
   input  logic [DW-1:0]   req0_a,
   input  logic [DW-1:0]   req0_b,
   input  logic [OPW-1:0]  req0_op,
   output logic            rsp0_valid,
   input  logic            rsp0_ready,
   output logic [DW-1:0]   rsp0_result,
   output logic            rsp0_err,

   input  logic            req1_valid,
   output logic            req1_ready,
   input  logic [DW-1:0]   req1_a,
   input  logic [DW-1:0]   req1_b,
   input  logic [OPW-1:0]  req1_op,
   output logic            rsp1_valid,
   input  logic            rsp1_ready,
   output logic [DW-1:0]   rsp1_result,
   output logic            rsp1_err,

   output logic [CNTW-1:0] op_count,
   output logic            busy
);

   state_t          state_q,       state_d;
   logic            last_grant_q,  last_grant_d;
   logic            owner_q,       owner_d;
   logic [DW-1:0]   a_q,           a_d;
   logic [DW-1:0]   b_q,           b_d;
   logic [OPW-1:0]  op_q,          op_d;
   logic            rsp0_valid_q,  rsp0_valid_d;
   logic [DW-1:0]   rsp0_result_q, rsp0_result_d;
   logic            rsp0_err_q,    rsp0_err_d;
   logic            rsp1_valid_q,  rsp1_valid_d;
   logic [DW-1:0]   rsp1_result_q, rsp1_result_d;
   logic            rsp1_err_q,    rsp1_err_d;
   logic [CNTW-1:0] op_count_q,    op_count_d;

   logic            grant_any;
   logic            grant_id;
   logic            accept;
   logic [DW-1:0]   alu_result;
   logic [DW-1:0]   cap_result;
   logic            cap_err;
   logic            owner_rsp_ready;

   alu16 u_alu16 (
      .A       (a_q),
      .B       (b_q),
      .ALUCtrl (op_q),
      .Result  (alu_result)
   );

   // Round-robin: a lone requester always wins; on contention the port that
   // was not served last wins.
   always_comb begin
      grant_any = req0_valid | req1_valid;
      if (req0_valid && req1_valid) begin
         grant_id = ~last_grant_q;
      end else begin
         grant_id = req1_valid;
      end
   end

   assign req0_ready = (state_q == IDLE) && grant_any && !grant_id;
   assign req1_ready = (state_q == IDLE) && grant_any &&  grant_id;
   assign accept     = (state_q == IDLE) && grant_any;

   // Error screening overrides whatever alu16 produced.
   always_comb begin
      cap_result = alu_result;
      cap_err    = 1'b0;
      if (!op_valid(op_q)) begin
         cap_result = '0;
         cap_err    = 1'b1;
      end else if (((op_q == OP_DIV) || (op_q == OP_MOD)) && (b_q == '0)) begin
         cap_result = ERR_DIV0_RESULT;
         cap_err    = 1'b1;
      end
   end

   assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      owner_d       = owner_q;
      a_d           = a_q;
      b_d           = b_q;
      op_d          = op_q;
      rsp0_valid_d  = rsp0_valid_q;
      rsp0_result_d = rsp0_result_q;
      rsp0_err_d    = rsp0_err_q;
      rsp1_valid_d  = rsp1_valid_q;
      rsp1_result_d = rsp1_result_q;
      rsp1_err_d    = rsp1_err_q;
      op_count_d    = op_count_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               owner_d      = grant_id;
               last_grant_d = grant_id;
               a_d          = grant_id ? req1_a  : req0_a;
               b_d          = grant_id ? req1_b  : req0_b;
               op_d         = grant_id ? req1_op : req0_op;
               state_d      = EXEC;
            end
         end
         EXEC: begin
            if (owner_q) begin
               rsp1_valid_d  = 1'b1;
               rsp1_result_d = cap_result;
               rsp1_err_d    = cap_err;
            end else begin
               rsp0_valid_d  = 1'b1;
               rsp0_result_d = cap_result;
               rsp0_err_d    = cap_err;
            end
            op_count_d = op_count_q + 1'b1;
            state_d    = RESP;
         end
         RESP: begin
            if (owner_rsp_ready) begin
               if (owner_q) begin
                  rsp1_valid_d = 1'b0;
               end else begin
                  rsp0_valid_d = 1'b0;
               end
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         last_grant_q  <= 1'b1;
         owner_q       <= 1'b0;
         a_q           <= '0;
         b_q           <= '0;
         op_q          <= '0;
         rsp0_valid_q  <= 1'b0;
         rsp0_result_q <= '0;
         rsp0_err_q    <= 1'b0;
         rsp1_valid_q  <= 1'b0;
         rsp1_result_q <= '0;
         rsp1_err_q    <= 1'b0;
         op_count_q    <= '0;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         owner_q       <= owner_d;
         a_q           <= a_d;
         b_q           <= b_d;
         op_q          <= op_d;
         rsp0_valid_q  <= rsp0_valid_d;
         rsp0_result_q <= rsp0_result_d;
         rsp0_err_q    <= rsp0_err_d;
         rsp1_valid_q  <= rsp1_valid_d;
         rsp1_result_q <= rsp1_result_d;
         rsp1_err_q    <= rsp1_err_d;
         op_count_q    <= op_count_d;
      end
   end

   assign rsp0_valid  = rsp0_valid_q;
   assign rsp0_result = rsp0_result_q;
   assign rsp0_err    = rsp0_err_q;
   assign rsp1_valid  = rsp1_valid_q;
   assign rsp1_result = rsp1_result_q;
   assign rsp1_err    = rsp1_err_q;
   assign op_count    = op_count_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter

module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0_valid = 0, req1_valid = 0;
   logic        req0_ready, req1_ready;
   logic [15:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
   logic [4:0]  req0_op = 0, req1_op = 0;
   logic        rsp0_valid, rsp1_valid;
   logic        rsp0_ready = 1, rsp1_ready = 1;
   logic [15:0] rsp0_result, rsp1_result;
   logic        rsp0_err, rsp1_err;
   logic [15:0] op_count;
   logic        busy;

   alu_arbiter #(.DW(16), .OPW(5), .CNTW(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
      .req0_b(req0_b), .req0_op(req0_op),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp0_result(rsp0_result), .rsp0_err(rsp0_err),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
      .req1_b(req1_b), .req1_op(req1_op),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp1_result(rsp1_result), .rsp1_err(rsp1_err),
      .op_count(op_count), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state: 0 idle, 1 computing, 2 response outstanding.
   int          phase = 0;
   logic        owner = 0;
   logic        last  = 1;
   int          model_cnt = 0;
   logic [16:0] exp_q0[$];
   logic [16:0] exp_q1[$];
   logic [17:0] done_q[$];   // {port, err, result} as delivered by the DUT
   logic        acc0 = 0, acc1 = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // {err, result} from the operation's arithmetic definition.
   function automatic logic [16:0] ref_op(input logic [15:0] a, input logic [15:0] b,
                                          input logic [4:0] op);
      int unsigned ua, ub, r;
      ua = a; ub = b; r = 0;
      case (op)
         5'd0: r = ua + ub;
         5'd1: r = ua - ub;
         5'd2: r = ua & ub;
         5'd3: r = ua | ub;
         5'd4: r = ua ^ ub;
         5'd5: r = ua * ub;
         5'd7: begin if (ub == 0) return {1'b1, 16'hFFFF}; r = ua / ub; end
         5'd8: r = ~ua;
         5'd9: begin if (ub == 0) return {1'b1, 16'hFFFF}; r = ua % ub; end
         default: return {1'b1, 16'h0000};
      endcase
      return {1'b0, r[15:0]};
   endfunction

   task automatic clear_model();
      phase = 0; owner = 0; last = 1; model_cnt = 0;
      exp_q0.delete(); exp_q1.delete(); done_q.delete();
      acc0 = 0; acc1 = 0;
   endtask

   // Protocol / arbitration checker.
   initial begin
      logic any, gid;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            check("busy", busy, phase != 0);
            check("op_count", op_count, model_cnt[15:0]);
            if (phase == 0) begin
               any = req0_valid | req1_valid;
               gid = (req0_valid && req1_valid) ? ~last : req1_valid;
               check("req0_ready", req0_ready, any && !gid);
               check("req1_ready", req1_ready, any && gid);
               check("idle_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
               if (any) begin
                  if (gid) begin exp_q1.push_back(ref_op(req1_a, req1_b, req1_op)); acc1 = 1; end
                  else     begin exp_q0.push_back(ref_op(req0_a, req0_b, req0_op)); acc0 = 1; end
                  owner = gid; last = gid; phase = 1;
               end
            end else if (phase == 1) begin
               check("exec_ready", {req1_ready, req0_ready}, 0);
               check("exec_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
               model_cnt++;
               phase = 2;
            end else begin
               check("resp_ready", {req1_ready, req0_ready}, 0);
               check("resp_valid", {rsp1_valid, rsp0_valid}, owner ? 2'b10 : 2'b01);
               if (owner ? rsp1_ready : rsp0_ready) phase = 0;
            end
         end
      end
   end

   // Response monitor: pops the scoreboard whenever a response is presented.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (rsp0_valid) begin
               if (exp_q0.size() == 0) begin
                  n_checks++; $display("FAIL rsp0_unexpected: got %0h expected none", rsp0_result);
               end else begin
                  check("rsp0_result", rsp0_result, exp_q0[0][15:0]);
                  check("rsp0_err", rsp0_err, exp_q0[0][16]);
                  if (rsp0_ready) begin
                     done_q.push_back({1'b0, rsp0_err, rsp0_result});
                     void'(exp_q0.pop_front());
                  end
               end
            end
            if (rsp1_valid) begin
               if (exp_q1.size() == 0) begin
                  n_checks++; $display("FAIL rsp1_unexpected: got %0h expected none", rsp1_result);
               end else begin
                  check("rsp1_result", rsp1_result, exp_q1[0][15:0]);
                  check("rsp1_err", rsp1_err, exp_q1[0][16]);
                  if (rsp1_ready) begin
                     done_q.push_back({1'b1, rsp1_err, rsp1_result});
                     void'(exp_q1.pop_front());
                  end
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic drop_accepted();
      if (acc0) begin req0_valid = 0; acc0 = 0; end
      if (acc1) begin req1_valid = 0; acc1 = 0; end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rsp_valid"}, {rsp1_valid, rsp0_valid}, 0);
      check({tag, "_rsp0_res"}, rsp0_result, 0);
      check({tag, "_rsp1_res"}, rsp1_result, 0);
      check({tag, "_err"}, {rsp1_err, rsp0_err}, 0);
      check({tag, "_op_count"}, op_count, 0);
      check({tag, "_busy"}, busy, 0);
   endtask

   task automatic do_reset();
      rst_n = 0;
      req0_valid = 0; req1_valid = 0;
      clear_model();
      repeat (2) @(negedge clk);
      check_reset_outputs("rst");
      step();
      rst_n = 1;
   endtask

   task automatic set_req(input bit p, input logic [15:0] a, input logic [15:0] b,
                          input logic [4:0] op);
      if (p) begin req1_valid = 1; req1_a = a; req1_b = b; req1_op = op; end
      else   begin req0_valid = 1; req0_a = a; req0_b = b; req0_op = op; end
   endtask

   task automatic send_one(input bit p, input logic [15:0] a, input logic [15:0] b,
                           input logic [4:0] op);
      set_req(p, a, b, op);
      for (int n = 0; n < 20; n++) begin
         step();
         if (p ? acc1 : acc0) begin drop_accepted(); return; end
      end
      n_checks++; $display("FAIL send_timeout: got no grant expected grant on port %0d", p);
      req0_valid = 0; req1_valid = 0;
   endtask

   task automatic run_until_idle(input string name);
      for (int n = 0; n < 60; n++) begin
         step();
         drop_accepted();
         if (!req0_valid && !req1_valid && phase == 0) return;
      end
      n_checks++; $display("FAIL %s_timeout: got busy expected idle", name);
   endtask

   initial begin
      logic [4:0] vops [9];
      vops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd7, 5'd8, 5'd9};

      do_reset();

      // Lone port 0 ADD.
      send_one(0, 16'd3, 16'd2, 5'b00000);
      run_until_idle("t1");
      check("t1_count", done_q.size(), 1);
      if (done_q.size() >= 1) check("t1_rsp", done_q[0], {1'b0, 1'b0, 16'd5});
      check("t1_op_count", op_count, 1);

      // Simultaneous requests after reset: port 0 first.
      do_reset();
      set_req(0, 16'd3, 16'd2, 5'b00000);
      set_req(1, 16'd3, 16'd4, 5'b00101);
      run_until_idle("t2");
      check("t2_count", done_q.size(), 2);
      if (done_q.size() >= 2) begin
         check("t2_first", done_q[0], {1'b0, 1'b0, 16'd5});
         check("t2_second", done_q[1], {1'b1, 1'b0, 16'd12});
      end
      done_q.delete();

      // Divide by zero and modulo on port 1.
      send_one(1, 16'd8, 16'd0, 5'b00111);
      run_until_idle("t3a");
      send_one(1, 16'd9, 16'd4, 5'b01001);
      run_until_idle("t3b");
      check("t3_count", done_q.size(), 2);
      if (done_q.size() >= 2) begin
         check("t3_div0", done_q[0], {1'b1, 1'b1, 16'hFFFF});
         check("t3_mod", done_q[1], {1'b1, 1'b0, 16'd1});
      end
      done_q.delete();

      // Undefined opcode still counts as a completed operation.
      send_one(0, 16'd1, 16'd1, 5'b11111);
      run_until_idle("t4");
      if (done_q.size() >= 1) check("t4_badop", done_q[0], {1'b0, 1'b1, 16'd0});
      else begin n_checks++; $display("FAIL t4_badop: got no response expected one"); end
      check("t4_op_count", op_count, 5);
      done_q.delete();

      // Response back-pressure blocks the other port.
      rsp0_ready = 0;
      send_one(0, 16'd1, 16'd1, 5'b00000);
      set_req(1, 16'd2, 16'd2, 5'b00000);
      repeat (6) begin
         @(negedge clk);
         check("t5_req1_blocked", req1_ready, 0);
      end
      @(posedge clk); #1;
      rsp0_ready = 1;
      run_until_idle("t5");
      check("t5_count", done_q.size(), 2);
      if (done_q.size() >= 2) begin
         check("t5_first", done_q[0], {1'b0, 1'b0, 16'd2});
         check("t5_second", done_q[1], {1'b1, 1'b0, 16'd4});
      end

      // Reset while the ALU operation is in flight.
      send_one(0, 16'd7, 16'd7, 5'b00000);
      #1;
      rst_n = 0;
      clear_model();
      #1;
      check_reset_outputs("mid_rst");
      repeat (2) step();
      rst_n = 1;
      set_req(0, 16'd5, 16'd6, 5'b00000);
      set_req(1, 16'd1, 16'd2, 5'b00001);
      run_until_idle("t6");
      check("t6_count", done_q.size(), 2);
      if (done_q.size() >= 2) begin
         check("t6_first", done_q[0], {1'b0, 1'b0, 16'd11});
         check("t6_second", done_q[1], {1'b1, 1'b0, 16'hFFFF});
      end
      done_q.delete();

      // Randomized traffic with random back-pressure and abandoned requests.
      for (int c = 0; c < 1500; c++) begin
         step();
         drop_accepted();
         rsp0_ready = ($urandom % 4) != 0;
         rsp1_ready = ($urandom % 4) != 0;
         for (int p = 0; p < 2; p++) begin
            logic v;
            v = (p == 0) ? req0_valid : req1_valid;
            if (!v && ($urandom % 3) == 0) begin
               set_req(p[0], ($urandom % 2) ? 16'($urandom) : 16'($urandom % 20),
                       ($urandom % 6 == 0) ? 16'd0 : 16'($urandom),
                       ($urandom % 5 == 0) ? 5'($urandom) : vops[$urandom % 9]);
            end else if (v && ($urandom % 12) == 0 && !(p == 0 ? acc0 : acc1)) begin
               if (p == 0) req0_valid = 0; else req1_valid = 0;
            end
         end
      end
      rsp0_ready = 1; rsp1_ready = 1;
      run_until_idle("rand");
      check("rand_drain", exp_q0.size() + exp_q1.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
